hci_l2_bank_arbiter: RTL and testbench

//  Per-bank arbiter placed in front of one L2 SRAM bank. Shares the bank between N_CH0

---
 rtl/hci_l2_bank_arbiter_pkg.sv | 14 +
 rtl/hci_l2_bank_arbiter_rr_pick.sv | 30 +++
 rtl/hci_l2_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_hci_l2_bank_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_l2_bank_arbiter_pkg.sv
// Shared types for the L2 bank arbiter: arbitration state and an index-width helper.
package hci_l2_bank_arbiter_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        BOOST  = 1'b1
    } hci_l2_arb_state_e;

    // Index width for an n-entry group; single-entry groups still need one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hci_l2_bank_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at N.
module hci_rr_pick
    import hci_l2_bank_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int c;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        for (int i = 0; i < int'(N); i++) begin
            c = int'(ptr) + i;
            if (c >= int'(N)) c = c - int'(N);
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/hci_l2_bank_arbiter.sv
// Per-bank L2 arbiter: strict CH0-over-CH1 priority with a starvation boost,
// round-robin inside each group, and one-cycle read response routing.
module hci_l2_bank_arbiter
    import hci_l2_bank_arbiter_pkg::*;
#(
    parameter int unsigned N_CH0      = 16,
    parameter int unsigned N_CH1      = 4,
    parameter int unsigned AW         = 30,
    parameter int unsigned DW         = 32,
    parameter int unsigned BW         = 8,
    parameter int unsigned STARVE_MAX = 8,
    localparam int unsigned N         = N_CH0 + N_CH1,
    localparam int unsigned BEW       = DW / BW,
    localparam int unsigned P0W       = idx_w(N_CH0),
    localparam int unsigned P1W       = idx_w(N_CH1),
    localparam int unsigned IDXW      = idx_w(N),
    localparam int unsigned CW        = $clog2(STARVE_MAX + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [N-1:0]          req_i,
    input  logic [N-1:0][AW-1:0]  add_i,
    input  logic [N-1:0]          wen_i,
    input  logic [N-1:0][DW-1:0]  data_i,
    input  logic [N-1:0][BEW-1:0] be_i,
    output logic [N-1:0]          gnt_o,
    output logic [N-1:0]          r_valid_o,
    output logic [DW-1:0]         r_data_o,
    output logic                  mem_req_o,
    output logic [AW-1:0]         mem_add_o,
    output logic                  mem_wen_o,
    output logic [DW-1:0]         mem_data_o,
    output logic [BEW-1:0]        mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic [DW-1:0]         mem_r_data_i,
    output hci_l2_arb_state_e     dbg_state,
    output logic [P0W-1:0]        dbg_rr_ptr0,
    output logic [P1W-1:0]        dbg_rr_ptr1,
    output logic [CW-1:0]         dbg_starve_cnt
);

    hci_l2_arb_state_e state;
    logic [P0W-1:0]    rr_ptr0;
    logic [P1W-1:0]    rr_ptr1;
    logic [CW-1:0]     starve_cnt;
    logic [CW-1:0]     starve_cnt_next;
    logic [IDXW-1:0]   tag;
    logic              rvld;

    logic [P0W-1:0]    idx0;
    logic [P1W-1:0]    idx1;
    logic              any0;
    logic              any1;
    logic              sel1;
    logic              hs;
    logic [IDXW-1:0]   winner;

    hci_rr_pick #(.N(N_CH0), .IW(P0W)) u_pick0 (
        .req   (req_i[N_CH0-1:0]),
        .ptr   (rr_ptr0),
        .idx   (idx0),
        .valid (any0)
    );

    hci_rr_pick #(.N(N_CH1), .IW(P1W)) u_pick1 (
        .req   (req_i[N-1:N_CH0]),
        .ptr   (rr_ptr1),
        .idx   (idx1),
        .valid (any1)
    );

    // BOOST hands CH1 the bank whenever it asks; NORMAL only falls back to CH1 when CH0 is idle.
    assign sel1   = (state == BOOST) ? any1 : (!any0 && any1);
    assign winner = sel1 ? (IDXW'(N_CH0) + IDXW'(idx1)) : IDXW'(idx0);

    assign mem_req_o  = |req_i;
    assign hs         = mem_req_o && mem_gnt_i;
    assign mem_add_o  = add_i[winner];
    assign mem_wen_o  = wen_i[winner];
    assign mem_data_o = data_i[winner];
    assign mem_be_o   = be_i[winner];

    always_comb begin
        gnt_o = '0;
        if (hs) gnt_o[winner] = 1'b1;
    end

    always_comb begin
        r_valid_o = '0;
        if (rvld) r_valid_o[tag] = 1'b1;
    end

    assign r_data_o = mem_r_data_i;

    // Counter sees the CH1 win, CH0-over-waiting-CH1 increment, and BOOST idle-exit clear.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (hs && sel1) begin
            starve_cnt_next = '0;
        end else if (hs && any1) begin
            if (starve_cnt != CW'(STARVE_MAX)) starve_cnt_next = starve_cnt + 1'b1;
        end else if (state == BOOST && !any1) begin
            starve_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= NORMAL;
            rr_ptr0    <= '0;
            rr_ptr1    <= '0;
            starve_cnt <= '0;
            tag        <= '0;
            rvld       <= 1'b0;
        end else if (clear_i) begin
            state      <= NORMAL;
            rr_ptr0    <= '0;
            rr_ptr1    <= '0;
            starve_cnt <= '0;
            tag        <= '0;
            rvld       <= 1'b0;
        end else begin
            rvld       <= hs;
            starve_cnt <= starve_cnt_next;
            if (hs) begin
                tag <= winner;
                if (sel1) rr_ptr1 <= (idx1 == P1W'(N_CH1 - 1)) ? '0 : idx1 + 1'b1;
                else      rr_ptr0 <= (idx0 == P0W'(N_CH0 - 1)) ? '0 : idx0 + 1'b1;
            end
            // Entering BOOST on the same edge the count saturates gives CH1 the very next slot.
            case (state)
                NORMAL: if (starve_cnt_next == CW'(STARVE_MAX)) state <= BOOST;
                BOOST:  if ((hs && sel1) || !any1) state <= NORMAL;
                default: state <= NORMAL;
            endcase
        end
    end

    assign dbg_state      = state;
    assign dbg_rr_ptr0    = rr_ptr0;
    assign dbg_rr_ptr1    = rr_ptr1;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_hci_l2_bank_arbiter.sv
// Directed bench for hci_l2_bank_arbiter: grant order, data routing, starvation boost, clear, reset.
module tb_hci_l2_bank_arbiter;
    import hci_l2_bank_arbiter_pkg::*;

    localparam int N = 20;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                clear_i;
    logic [N-1:0]        req_i;
    logic [N-1:0][29:0]  add_i;
    logic [N-1:0]        wen_i;
    logic [N-1:0][31:0]  data_i;
    logic [N-1:0][3:0]   be_i;
    logic [N-1:0]        gnt_o;
    logic [N-1:0]        r_valid_o;
    logic [31:0]         r_data_o;
    logic                mem_req_o;
    logic [29:0]         mem_add_o;
    logic                mem_wen_o;
    logic [31:0]         mem_data_o;
    logic [3:0]          mem_be_o;
    logic                mem_gnt_i;
    logic [31:0]         mem_r_data_i;
    hci_l2_arb_state_e   dbg_state;
    logic [3:0]          dbg_rr_ptr0;
    logic [1:0]          dbg_rr_ptr1;
    logic [3:0]          dbg_starve_cnt;

    int checks = 0;
    int errors = 0;

    hci_l2_bank_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .req_i          (req_i),
        .add_i          (add_i),
        .wen_i          (wen_i),
        .data_i         (data_i),
        .be_i           (be_i),
        .gnt_o          (gnt_o),
        .r_valid_o      (r_valid_o),
        .r_data_o       (r_data_o),
        .mem_req_o      (mem_req_o),
        .mem_add_o      (mem_add_o),
        .mem_wen_o      (mem_wen_o),
        .mem_data_o     (mem_data_o),
        .mem_be_o       (mem_be_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_r_data_i   (mem_r_data_i),
        .dbg_state      (dbg_state),
        .dbg_rr_ptr0    (dbg_rr_ptr0),
        .dbg_rr_ptr1    (dbg_rr_ptr1),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [N-1:0] bit_at(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        req_i        = '0;
        wen_i        = '1;
        data_i       = '0;
        be_i         = '1;
        mem_gnt_i    = 1'b1;
        mem_r_data_i = '0;
        for (int i = 0; i < N; i++) add_i[i] = 30'(i * 256);

        #12;
        check("rst_gnt",   64'(gnt_o), 64'(0));
        check("rst_rvld",  64'(r_valid_o), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(NORMAL));
        check("rst_ptr0",  64'(dbg_rr_ptr0), 64'(0));
        check("rst_ptr1",  64'(dbg_rr_ptr1), 64'(0));
        check("rst_cnt",   64'(dbg_starve_cnt), 64'(0));
        rst_ni = 1'b1;
        tick();

        // ch0 and ch3 request; each master drops its request once granted
        req_i = bit_at(0) | bit_at(3);
        #1;
        check("two_gnt0", 64'(gnt_o), 64'(bit_at(0)));
        check("two_add0", 64'(mem_add_o), 64'(30'h000));
        tick();
        check("two_rv0", 64'(r_valid_o), 64'(bit_at(0)));
        req_i = bit_at(3);
        #1;
        check("two_gnt3", 64'(gnt_o), 64'(bit_at(3)));
        check("two_add3", 64'(mem_add_o), 64'(30'h300));
        tick();
        check("two_rv3", 64'(r_valid_o), 64'(bit_at(3)));
        check("two_ptr0", 64'(dbg_rr_ptr0), 64'(4));

        // read on ch5 at 0x40
        add_i[5] = 30'h40;
        req_i    = bit_at(5);
        #1;
        check("rd_gnt", 64'(gnt_o), 64'(bit_at(5)));
        check("rd_add", 64'(mem_add_o), 64'(30'h40));
        check("rd_wen", 64'(mem_wen_o), 64'(1));
        tick();
        req_i        = '0;
        mem_r_data_i = 32'hDEADBEEF;
        #1;
        check("rd_rv",   64'(r_valid_o), 64'(bit_at(5)));
        check("rd_data", 64'(r_data_o), 64'(32'hDEADBEEF));
        check("rd_ptr0", 64'(dbg_rr_ptr0), 64'(6));

        // write on ch7
        wen_i[7]  = 1'b0;
        data_i[7] = 32'hCAFE0123;
        be_i[7]   = 4'b0101;
        req_i     = bit_at(7);
        #1;
        check("wr_gnt",  64'(gnt_o), 64'(bit_at(7)));
        check("wr_wen",  64'(mem_wen_o), 64'(0));
        check("wr_data", 64'(mem_data_o), 64'(32'hCAFE0123));
        check("wr_be",   64'(mem_be_o), 64'(4'b0101));
        tick();
        req_i = '0;
        check("wr_rv",   64'(r_valid_o), 64'(bit_at(7)));
        check("wr_ptr0", 64'(dbg_rr_ptr0), 64'(8));

        // bank stalls three cycles with ch2, ch9, ch17 held
        req_i     = bit_at(2) | bit_at(9) | bit_at(17);
        mem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_gnt", 64'(gnt_o), 64'(0));
            check("stall_req", 64'(mem_req_o), 64'(1));
            check("stall_add", 64'(mem_add_o), 64'(30'h900));
            tick();
            check("stall_rv",   64'(r_valid_o), 64'(0));
            check("stall_ptr0", 64'(dbg_rr_ptr0), 64'(8));
            check("stall_cnt",  64'(dbg_starve_cnt), 64'(0));
        end
        mem_gnt_i = 1'b1;
        #1;
        check("unstall_gnt", 64'(gnt_o), 64'(bit_at(9)));
        tick();
        req_i = '0;
        check("unstall_rv",   64'(r_valid_o), 64'(bit_at(9)));
        check("unstall_ptr0", 64'(dbg_rr_ptr0), 64'(10));
        check("unstall_cnt",  64'(dbg_starve_cnt), 64'(1));

        // standalone clear
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_ptr0", 64'(dbg_rr_ptr0), 64'(0));
        check("clr_cnt",  64'(dbg_starve_cnt), 64'(0));

        // all CH0 requesting: rotate 0..15 then 0
        req_i = 20'h0FFFF;
        for (int i = 0; i < 17; i++) begin
            #1;
            check("rot_gnt", 64'(gnt_o), 64'(bit_at(i % 16)));
            tick();
        end
        check("rot_ptr0", 64'(dbg_rr_ptr0), 64'(1));
        check("rot_cnt",  64'(dbg_starve_cnt), 64'(0));

        // ch0 vs ch16 forever: eight CH0 wins then one CH1 win
        req_i = bit_at(0) | bit_at(16);
        for (int k = 0; k < 27; k++) begin
            #1;
            check("starve_gnt", 64'(gnt_o), 64'((k % 9 == 8) ? bit_at(16) : bit_at(0)));
            tick();
        end
        check("starve_state", 64'(dbg_state), 64'(NORMAL));
        for (int k = 0; k < 8; k++) begin
            #1;
            check("boost_pre_gnt", 64'(gnt_o), 64'(bit_at(0)));
            tick();
        end
        check("boost_state", 64'(dbg_state), 64'(BOOST));
        check("boost_cnt",   64'(dbg_starve_cnt), 64'(8));

        // clear concurrent with a BOOST handshake
        req_i   = bit_at(4) | bit_at(16);
        clear_i = 1'b1;
        #1;
        check("clrhs_gnt", 64'(gnt_o), 64'(bit_at(16)));
        tick();
        clear_i = 1'b0;
        check("clrhs_rv",    64'(r_valid_o), 64'(0));
        check("clrhs_state", 64'(dbg_state), 64'(NORMAL));
        check("clrhs_cnt",   64'(dbg_starve_cnt), 64'(0));
        check("clrhs_ptr0",  64'(dbg_rr_ptr0), 64'(0));
        check("clrhs_ptr1",  64'(dbg_rr_ptr1), 64'(0));

        // rebuild BOOST, then withdraw CH1 so BOOST drops back
        req_i = bit_at(0) | bit_at(16);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("boost2_gnt", 64'(gnt_o), 64'(bit_at(0)));
            tick();
        end
        check("boost2_state", 64'(dbg_state), 64'(BOOST));
        req_i = bit_at(0);
        #1;
        check("idle1_gnt", 64'(gnt_o), 64'(bit_at(0)));
        tick();
        check("idle1_state", 64'(dbg_state), 64'(NORMAL));
        check("idle1_cnt",   64'(dbg_starve_cnt), 64'(0));

        // async reset while a response is being presented
        req_i = bit_at(1);
        tick();
        check("ar_rv_pre", 64'(r_valid_o), 64'(bit_at(1)));
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_rv",    64'(r_valid_o), 64'(0));
        check("ar_ptr0",  64'(dbg_rr_ptr0), 64'(0));
        check("ar_state", 64'(dbg_state), 64'(NORMAL));
        req_i  = '0;
        rst_ni = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
